// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port (A=CPU, B=DMA) data-memory arbiter, 3-cycle access; define DM_ARBITER_FIXED_PRIO_EN for fixed A priority
module dm_arbiter #(
  parameter int DEPTH = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [7:0]    a_rdata,
  output logic          a_err,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [7:0]    b_rdata,
  output logic          b_err,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic owner, l_we, win, in_rng, acc, rsp, any_req;
  logic [AW-1:0] l_addr;
  logic [7:0] l_wdata;
`ifdef DM_ARBITER_FIXED_PRIO_EN
  assign win = !a_req;
`else
  logic prio;
  assign win = (a_req && b_req) ? prio : !a_req;
`endif
  assign any_req = a_req || b_req;
  assign acc = state == ACCESS;
  assign rsp = state == RESP;
  assign in_rng = 32'(l_addr) < DEPTH;
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (any_req ? ACCESS : IDLE) : (acc ? RESP : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      l_we <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
`ifndef DM_ARBITER_FIXED_PRIO_EN
      prio <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner <= win;
        l_we <= win ? b_we : a_we;
        l_addr <= win ? b_addr : a_addr;
        l_wdata <= win ? b_wdata : a_wdata;
`ifndef DM_ARBITER_FIXED_PRIO_EN
        prio <= !win;
`endif
      end
      if (acc && !l_we && in_rng && !owner) a_rdata <= mem_rdata;
      if (acc && !l_we && in_rng && owner) b_rdata <= mem_rdata;
    end
  end
  assign a_gnt = acc && !owner;
  assign b_gnt = acc && owner;
  assign a_rvalid = rsp && !owner;
  assign b_rvalid = rsp && owner;
  assign a_err = rsp && !owner && !in_rng;
  assign b_err = rsp && owner && !in_rng;
  assign mem_addr = acc ? l_addr : '0;
  assign mem_wdata = acc ? l_wdata : '0;
  // out-of-range or reset-interrupted accesses never touch memory
  assign mem_write = !rst && acc && in_rng && l_we;
  assign mem_read = !rst && acc && in_rng && !l_we;
  assign busy = state != IDLE;
endmodule
